// File: rtl/btn_event_pkg.sv
// btn_event_pkg: shared state encoding and counter sizing for the button event detector
package btn_event_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HELD  = 3'd1,
        LONG  = 3'd2,
        GAP   = 3'd3,
        HELD2 = 3'd4
    } state_t;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/btn_event_channel.sv
// btn_event_channel: classifies one debounced button into press/release/click/long/double pulses
module btn_event_channel
    import btn_event_pkg::*;
#(
    parameter int LONG_CLOCKS   = 125000000,
    parameter int DCLICK_CLOCKS = 31250000
) (
    input  logic sysclk,
    input  logic rst,
    input  logic din,
    output logic held,
    output logic press,
    output logic released,
    output logic short_click,
    output logic long_press,
    output logic double_click
);

    localparam int CW = cnt_width(LONG_CLOCKS, DCLICK_CLOCKS);
    localparam logic [CW-1:0] LONG_TC = CW'(LONG_CLOCKS - 1);
    localparam logic [CW-1:0] DC_TC   = CW'(DCLICK_CLOCKS - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          rise;
    logic          fall;

    assign rise = din & ~held;
    assign fall = ~din & held;

    // Edge pulses every cycle; gesture FSM advances and counts only in HELD and GAP
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            held         <= 1'b0;
            press        <= 1'b0;
            released     <= 1'b0;
            short_click  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
        end else begin
            held         <= din;
            press        <= rise;
            released     <= fall;
            short_click  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
            cnt          <= '0;
            case (state)
                IDLE:  state <= rise ? HELD : IDLE;
                HELD: begin
                    if (fall) begin
                        state <= GAP;
                    end else if (cnt == LONG_TC) begin
                        long_press <= 1'b1;
                        state      <= LONG;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LONG:  state <= fall ? IDLE : LONG;
                GAP: begin
                    if (rise) begin
                        double_click <= 1'b1;
                        state        <= HELD2;
                    end else if (cnt == DC_TC) begin
                        short_click <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD2: state <= fall ? IDLE : HELD2;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/btn_event_detector.sv
// btn_event_detector: WIDTH independent button gesture classifiers
module btn_event_detector
    import btn_event_pkg::*;
#(
    parameter int WIDTH         = 2,
    parameter int LONG_CLOCKS   = 125000000,
    parameter int DCLICK_CLOCKS = 31250000
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] held,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] released,
    output logic [WIDTH-1:0] short_click,
    output logic [WIDTH-1:0] long_press,
    output logic [WIDTH-1:0] double_click
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        btn_event_channel #(
            .LONG_CLOCKS  (LONG_CLOCKS),
            .DCLICK_CLOCKS(DCLICK_CLOCKS)
        ) u_ch (
            .sysclk      (sysclk),
            .rst         (rst),
            .din         (din[i]),
            .held        (held[i]),
            .press       (press[i]),
            .released    (released[i]),
            .short_click (short_click[i]),
            .long_press  (long_press[i]),
            .double_click(double_click[i])
        );
    end

endmodule

// File: doc/btn_event_detector.md
Name: btn_event_detector

Overview:
Sits directly downstream of the button debouncer and upstream of the LED/colour control logic. It takes WIDTH debounced, sysclk-synchronous button levels and classifies each button's activity into single-cycle event pulses: press, release, short click, long press and double click. It lets LED-sequence logic react to gestures instead of raw levels. Each channel is fully independent.

Parameters:
WIDTH, 2, number of button channels.
LONG_CLOCKS, 125000000, hold duration (sysclk cycles) before a long-press event; must be ≥ 2.
DCLICK_CLOCKS, 31250000, maximum release-to-re-press gap (sysclk cycles) for a double click; must be ≥ 2.

Ports:
sysclk  input  1  125 MHz system clock; all logic on the rising edge.
rst  input  1  reset: asynchronous, active-high.
din  input  WIDTH  debounced button levels, 1 = pressed; synchronous to sysclk.
held  output  WIDTH  registered copy of din (din_q).
press  output  WIDTH  1-cycle pulse on each 0→1 of din.
release  output  WIDTH  1-cycle pulse on each 1→0 of din.
short_click  output  WIDTH  1-cycle pulse: a single press/release shorter than LONG_CLOCKS, with no re-press within the gap window.
long_press  output  WIDTH  1-cycle pulse once a press has been held LONG_CLOCKS cycles.
double_click  output  WIDTH  1-cycle pulse on the second press of a double click.

Behaviour:
- Reset (async assert, sync release): every output 0, din_q 0, every channel in IDLE, counters 0. Reset mid-gesture discards it; no event is emitted.
- Because din_q resets to 0, a button held across reset release produces press one cycle after the first sampling edge.
- rise = din & ~din_q; fall = ~din & din_q. These are evaluated per channel from the sampled din.
- All event outputs are registered. If rise or fall is sampled at edge k, the pulse is high for exactly the cycle from edge k to edge k+1.
- Events never stretch beyond one cycle.
- press and release follow every edge in every state, independent of classification.
- Per-channel FSM with states IDLE, HELD, LONG, GAP, HELD2. One counter per channel is held at 0 on state entry and incremented each cycle in HELD and GAP. Counter width is clog2(max(LONG_CLOCKS, DCLICK_CLOCKS)).
- IDLE: on rise → HELD.
- HELD, rise counted as count 0:
  - fall while count < LONG_CLOCKS-1 → GAP.
  - count == LONG_CLOCKS-1 with din still 1 → pulse long_press, → LONG.
  - fall and terminal count in the same cycle: fall wins → GAP, no long_press.
- LONG: on fall → IDLE. No click event is emitted.
- GAP:
  - rise while count ≤ DCLICK_CLOCKS-1 → pulse double_click, → HELD2.
  - count == DCLICK_CLOCKS-1 with no rise → pulse short_click, → IDLE.
  - rise on the terminal-count cycle: rise wins → double_click only.
- HELD2: on fall → IDLE. No long_press is emitted however long the hold lasts. A third quick press starts a fresh gesture from IDLE.
- short_click timing: it lags the release by exactly DCLICK_CLOCKS cycles.
- Channel independence: simultaneous events on different channels all assert in the same cycle.
- Illegal or unused state encodings recover to IDLE on the next edge.

Decomposition:
- Package btn_event_pkg holds:
  - state typedef/encoding: IDLE=0, HELD=1, LONG=2, GAP=3, HELD2=4;
  - a clog2-max counter-width helper function.
- Sub-module btn_event_channel implements one channel: din_q, the FSM, the counter, and five registered pulses.
- btn_event_detector instantiates btn_event_channel WIDTH times with a generate loop and concatenates the outputs.

Test Plan:
All scenarios use LONG_CLOCKS=20, DCLICK_CLOCKS=10, WIDTH=2.
1. Reset with din=00, then din[0] high for 5 cycles, then low → press[0] one cycle after rise; release[0] one cycle after fall; short_click[0] exactly 10 cycles after the fall; no other events.
2. din[0] high for 30 cycles → long_press[0] pulses once, 20 cycles after the rise edge; release on fall; no short_click or double_click.
3. din[1] pulses: 3 high, 4 low, 3 high, low → double_click[1] on the second rise cycle; press[1] twice; no short_click[1] after the final release.
4. Re-press exactly on gap count 9 → double_click only. Release exactly on HELD count 19 → no long_press; short_click follows 10 cycles later.
5. Assert rst during GAP, hold 3 cycles, release with din=00 → all outputs 0 and no short_click ever. Release rst with din[0]=1 → press[0] one cycle later.
6. Both channels driven with identical stimulus from scenario 1 → identical, simultaneous pulses on both bits.
